// File: rtl/aircon_mode_ctrl_pkg.sv
// Shared mode constants, state encoding and defaults for the aircon mode controller.
package aircon_mode_ctrl_pkg;

    // One-hot display codes; 0000 means the unit is off.
    localparam logic [3:0] ThermoOff      = 4'b0000;
    localparam logic [3:0] ThermoLowFan   = 4'b0001;
    localparam logic [3:0] ThermoHighFan  = 4'b0010;
    localparam logic [3:0] ThermoLowCool  = 4'b0100;
    localparam logic [3:0] ThermoHighCool = 4'b1000;

    localparam int unsigned TurboCyclesDefault = 16;
    localparam int unsigned TurboCntWidth      = 8;

    typedef enum logic [2:0] {
        StOff      = 3'd0,
        StLowFan   = 3'd1,
        StHighFan  = 3'd2,
        StLowCool  = 3'd3,
        StHighCool = 3'd4
    } mode_e;

    function automatic logic [3:0] mode_code(input mode_e m);
        logic [3:0] code;
        code = ThermoOff;
        unique case (m)
            StOff:      code = ThermoOff;
            StLowFan:   code = ThermoLowFan;
            StHighFan:  code = ThermoHighFan;
            StLowCool:  code = ThermoLowCool;
            StHighCool: code = ThermoHighCool;
            default:    code = ThermoOff;
        endcase
        return code;
    endfunction

    function automatic logic is_cool(input mode_e m);
        return (m == StLowCool) || (m == StHighCool);
    endfunction

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector for one synchronous button level.
module edge_rise (
    input  logic Clk,
    input  logic nReset,
    input  logic D_In,
    output logic Pulse_Out
);

    logic hist_q;

    // History resets high so a button held through reset release gives no event.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            hist_q <= 1'b1;
        end else begin
            hist_q <= D_In;
        end
    end

    assign Pulse_Out = D_In & ~hist_q;

endmodule

// File: rtl/aircon_mode_ctrl.sv
// Five-state aircon mode controller with timed turbo and rejected-request flag.
module aircon_mode_ctrl
    import aircon_mode_ctrl_pkg::*;
#(
    parameter int unsigned TURBO_CYCLES = TurboCyclesDefault
) (
    input  logic       Clk,
    input  logic       nReset,
    input  logic       Up_In,
    input  logic       Down_In,
    input  logic       Turbo_Btn_In,
    input  logic       Off_In,
    output logic [3:0] Thermo_Out,
    output logic       Turbo_Out,
    output logic       Err_Out
);

    localparam logic [TurboCntWidth-1:0] TurboLoad = TurboCntWidth'(TURBO_CYCLES);

    logic up_ev, down_ev, turbo_ev, off_ev;

    edge_rise u_edge_up (
        .Clk       (Clk),
        .nReset    (nReset),
        .D_In      (Up_In),
        .Pulse_Out (up_ev)
    );

    edge_rise u_edge_down (
        .Clk       (Clk),
        .nReset    (nReset),
        .D_In      (Down_In),
        .Pulse_Out (down_ev)
    );

    edge_rise u_edge_turbo (
        .Clk       (Clk),
        .nReset    (nReset),
        .D_In      (Turbo_Btn_In),
        .Pulse_Out (turbo_ev)
    );

    edge_rise u_edge_off (
        .Clk       (Clk),
        .nReset    (nReset),
        .D_In      (Off_In),
        .Pulse_Out (off_ev)
    );

    mode_e                    state_q, state_d;
    logic                     turbo_q, turbo_d;
    logic [TurboCntWidth-1:0] cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic [3:0]               thermo_q;

    // Next mode, turbo and error decision; turbo is judged against the next mode.
    always_comb begin
        state_d = state_q;
        turbo_d = turbo_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;

        if (turbo_q) begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_d == 8'd0) begin
                turbo_d = 1'b0;
            end
        end

        if (off_ev) begin
            state_d = StOff;
            turbo_d = 1'b0;
            cnt_d   = 8'd0;
        end else begin
            if (up_ev && down_ev) begin
                err_d = 1'b1;
            end else if (up_ev) begin
                unique case (state_q)
                    StOff:      state_d = StLowFan;
                    StLowFan:   state_d = StHighFan;
                    StHighFan:  state_d = StLowCool;
                    StLowCool:  state_d = StHighCool;
                    StHighCool: err_d   = 1'b1;
                    default:    state_d = StOff;
                endcase
            end else if (down_ev) begin
                unique case (state_q)
                    StOff:      err_d   = 1'b1;
                    StLowFan:   state_d = StOff;
                    StHighFan:  state_d = StLowFan;
                    StLowCool:  state_d = StHighFan;
                    StHighCool: state_d = StLowCool;
                    default:    state_d = StOff;
                endcase
            end

            // Leaving the cooling modes drops turbo on the same edge.
            if (!is_cool(state_d)) begin
                turbo_d = 1'b0;
                cnt_d   = 8'd0;
            end

            if (turbo_ev) begin
                if (!is_cool(state_d)) begin
                    err_d = 1'b1;
                end else if (turbo_q) begin
                    turbo_d = 1'b0;
                    cnt_d   = 8'd0;
                end else begin
                    turbo_d = 1'b1;
                    cnt_d   = TurboLoad;
                end
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q  <= StOff;
            turbo_q  <= 1'b0;
            cnt_q    <= 8'd0;
            err_q    <= 1'b0;
            thermo_q <= ThermoOff;
        end else begin
            state_q  <= state_d;
            turbo_q  <= turbo_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            thermo_q <= mode_code(state_d);
        end
    end

    assign Thermo_Out = thermo_q;
    assign Turbo_Out  = turbo_q;
    assign Err_Out    = err_q;

endmodule

// File: tb/tb_aircon_mode_ctrl.sv
// Scoreboard bench for aircon_mode_ctrl: a reference model queues expected outputs per cycle.
module tb_aircon_mode_ctrl;

    localparam int unsigned TC = 16;

    logic       Clk;
    logic       nReset;
    logic       Up_In, Down_In, Turbo_Btn_In, Off_In;
    logic [3:0] Thermo_Out;
    logic       Turbo_Out, Err_Out;

    aircon_mode_ctrl #(
        .TURBO_CYCLES (TC)
    ) dut (
        .Clk          (Clk),
        .nReset       (nReset),
        .Up_In        (Up_In),
        .Down_In      (Down_In),
        .Turbo_Btn_In (Turbo_Btn_In),
        .Off_In       (Off_In),
        .Thermo_Out   (Thermo_Out),
        .Turbo_Out    (Turbo_Out),
        .Err_Out      (Err_Out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [3:0] thermo;
        logic       turbo;
        logic       err;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    int m_mode;
    bit m_turbo;
    int m_cnt;
    bit h_up, h_dn, h_tb, h_off;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] code_of(input int m);
        logic [3:0] c;
        case (m)
            1:       c = 4'b0001;
            2:       c = 4'b0010;
            3:       c = 4'b0100;
            4:       c = 4'b1000;
            default: c = 4'b0000;
        endcase
        return c;
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_turbo = 0;
        m_cnt   = 0;
        h_up    = 1;
        h_dn    = 1;
        h_tb    = 1;
        h_off   = 1;
    endtask

    // Advance the model one clock and push the expected registered outputs.
    task automatic model_step(input bit up, input bit dn, input bit tb, input bit off);
        bit   eu, ed, et, eo, err, was_on;
        exp_t e;
        eu = up & ~h_up;
        ed = dn & ~h_dn;
        et = tb & ~h_tb;
        eo = off & ~h_off;
        h_up = up; h_dn = dn; h_tb = tb; h_off = off;
        err    = 0;
        was_on = m_turbo;
        if (m_turbo) begin
            m_cnt--;
            if (m_cnt == 0) m_turbo = 0;
        end
        if (eo) begin
            m_mode  = 0;
            m_turbo = 0;
            m_cnt   = 0;
        end else begin
            if (eu && ed) err = 1;
            else if (eu) begin
                if (m_mode == 4) err = 1;
                else m_mode++;
            end else if (ed) begin
                if (m_mode == 0) err = 1;
                else m_mode--;
            end
            if (m_mode < 3) begin
                m_turbo = 0;
                m_cnt   = 0;
            end
            if (et) begin
                if (m_mode < 3) err = 1;
                else if (was_on) begin
                    m_turbo = 0;
                    m_cnt   = 0;
                end else begin
                    m_turbo = 1;
                    m_cnt   = TC;
                end
            end
        end
        e.thermo = code_of(m_mode);
        e.turbo  = m_turbo;
        e.err    = err;
        exp_q.push_back(e);
    endtask

    // One clock with the given button levels; compares DUT against the queued expectation.
    task automatic step(input bit up, input bit dn, input bit tb, input bit off);
        exp_t e;
        @(negedge Clk);
        Up_In = up; Down_In = dn; Turbo_Btn_In = tb; Off_In = off;
        model_step(up, dn, tb, off);
        @(posedge Clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("thermo", 32'(Thermo_Out), 32'(e.thermo));
            check("turbo",  32'(Turbo_Out),  32'(e.turbo));
            check("err",    32'(Err_Out),    32'(e.err));
        end
    endtask

    task automatic press(input bit up, input bit dn, input bit tb, input bit off);
        step(up, dn, tb, off);
        step(0, 0, 0, 0);
    endtask

    // Assert reset between edges and confirm outputs clear immediately.
    task automatic async_reset(input int hold_cycles);
        @(negedge Clk);
        #2;
        nReset = 1'b0;
        #1;
        check("rst_thermo", 32'(Thermo_Out), 32'h0);
        check("rst_turbo",  32'(Turbo_Out),  32'h0);
        check("rst_err",    32'(Err_Out),    32'h0);
        model_reset();
        exp_q.delete();
        repeat (hold_cycles) @(negedge Clk);
        nReset = 1'b1;
    endtask

    int turbo_hi;

    initial begin
        nReset = 1'b1;
        Up_In = 0; Down_In = 0; Turbo_Btn_In = 0; Off_In = 0;
        model_reset();
        async_reset(2);
        step(0, 0, 0, 0);

        // Down at OFF is rejected.
        press(0, 1, 0, 0);

        // Four Up steps then a rejected fifth.
        repeat (4) press(1, 0, 0, 0);
        check("four_up_code", 32'(Thermo_Out), 32'h8);
        step(1, 0, 0, 0);
        check("fifth_up_err", 32'(Err_Out), 32'h1);
        step(0, 0, 0, 0);
        check("err_one_cycle", 32'(Err_Out), 32'h0);

        // LOW_COOL timed turbo.
        press(0, 1, 0, 0);
        step(0, 0, 1, 0);
        turbo_hi = 0;
        if (Turbo_Out) turbo_hi++;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0);
            if (Turbo_Out) turbo_hi++;
        end
        check("turbo_len", 32'(turbo_hi), 32'(TC));
        check("turbo_mode_kept", 32'(Thermo_Out), 32'h4);

        // Toggle off before expiry.
        press(0, 0, 1, 0);
        repeat (3) step(0, 0, 0, 0);
        press(0, 0, 1, 0);
        check("turbo_toggled_off", 32'(Turbo_Out), 32'h0);

        // HIGH_FAN rejects turbo; Up+Turbo lands in LOW_COOL with turbo.
        press(0, 1, 0, 0);
        press(0, 0, 1, 0);
        step(1, 0, 1, 0);
        check("up_turbo_code", 32'(Thermo_Out), 32'h4);
        check("up_turbo_on", 32'(Turbo_Out), 32'h1);
        step(0, 0, 0, 0);
        // Up into HIGH_COOL keeps turbo, then Off wins over everything.
        press(1, 0, 0, 0);
        step(1, 1, 0, 1);
        check("off_all_code", 32'(Thermo_Out), 32'h0);
        check("off_all_turbo", 32'(Turbo_Out), 32'h0);
        check("off_all_err", 32'(Err_Out), 32'h0);
        step(0, 0, 0, 0);

        // Held Up gives a single step; Up+Down rejected.
        repeat (10) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check("held_up_one_step", 32'(Thermo_Out), 32'h1);
        press(1, 1, 0, 0);

        // Down from LOW_COOL drops turbo.
        repeat (2) press(1, 0, 0, 0);
        press(0, 0, 1, 0);
        press(0, 1, 0, 0);

        // Reset mid-turbo with Up held through release.
        press(1, 0, 0, 0);
        press(0, 0, 1, 0);
        repeat (3) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        async_reset(3);
        repeat (5) step(1, 0, 0, 0);
        check("no_step_after_rst", 32'(Thermo_Out), 32'h0);
        step(0, 0, 0, 0);
        press(1, 0, 0, 0);
        check("repress_step", 32'(Thermo_Out), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aircon_mode_ctrl.md
AIRCON_MODE_CTRL -- requirements
Module: aircon_mode_ctrl

Interface
REQ-001 Parameter: TURBO_CYCLES, default 16; turbo duration in clock cycles, legal range 2..255.
REQ-002 Clk  input  1  system clock; all state updates on the rising edge.
REQ-003 nReset  input  1  reset; asynchronous assert, active-low.
REQ-004 Up_In  input  1  mode-up button; level, synchronous to Clk.
REQ-005 Down_In  input  1  mode-down button; level, synchronous to Clk.
REQ-006 Turbo_Btn_In  input  1  turbo request button; level, synchronous to Clk.
REQ-007 Off_In  input  1  force-off button; level, synchronous to Clk.
REQ-008 Thermo_Out  output  4  one-hot mode code to the display: 0000 OFF, 0001 LOW_FAN, 0010 HIGH_FAN, 0100 LOW_COOL, 1000 HIGH_COOL.
REQ-009 Turbo_Out  output  1  turbo active; drives the display turbo input.
REQ-010 Err_Out  output  1  one-cycle pulse flagging a rejected request.

Function
REQ-011 Each button input shall be rising-edge detected: event = current sample 1 and previous-cycle sample 0; a held button yields exactly one event.
REQ-012 The mode FSM shall have exactly five states: OFF, LOW_FAN, HIGH_FAN, LOW_COOL, HIGH_COOL; all outputs are registered.
REQ-013 An Up event shall advance one state in the order above; at HIGH_COOL it shall hold state and pulse Err_Out.
REQ-014 A Down event shall retreat one state; at OFF it shall hold state and pulse Err_Out.
REQ-015 An Off event shall force OFF and clear turbo from any state; it overrides all other events in the same cycle, and Err_Out stays 0.
REQ-016 Simultaneous Up and Down events without Off shall leave state unchanged and pulse Err_Out.
REQ-017 A Turbo event in LOW_COOL or HIGH_COOL with turbo off shall set Turbo_Out and load the turbo counter with TURBO_CYCLES.
REQ-018 A Turbo event with turbo already on shall clear Turbo_Out (toggle off).
REQ-019 A Turbo event in OFF, LOW_FAN or HIGH_FAN shall be ignored and pulse Err_Out.
REQ-020 While turbo is on, the counter shall decrement once per cycle; Turbo_Out shall clear on the edge where the counter reaches 0, so it is high for exactly TURBO_CYCLES cycles.
REQ-021 A transition out of the cooling states (LOW_COOL to HIGH_FAN via Down, or Off) shall clear turbo on that same edge.
REQ-022 LOW_COOL to HIGH_COOL via Up shall keep turbo and its remaining count.
REQ-023 A Turbo event in the same cycle as a mode event shall be evaluated against the next state; for example, Up from HIGH_FAN plus Turbo yields LOW_COOL with turbo on.
REQ-024 Latency: Thermo_Out, Turbo_Out and Err_Out shall change on the same Clk edge that detects the event, with no extra pipeline stage.
REQ-025 Err_Out shall be high for exactly one cycle per rejected event and shall be 0 otherwise.
REQ-026 Thermo_Out shall always be a legal one-hot code or 0000; it shall never drive the display error codes.

Reset
REQ-027 On nReset low, the block shall asynchronously set: state OFF, Thermo_Out 0000, Turbo_Out 0, Err_Out 0, turbo counter 0, all edge-detect history registers 1.
REQ-028 Because the history registers reset to 1, a button held through reset release shall produce no event.
REQ-029 Reset asserted mid-turbo or mid-transition shall abort immediately; no residual event or Err pulse shall appear after release.

Structure
REQ-030 A shared package shall hold the five one-hot mode constants, the state enumeration, and the TURBO_CYCLES default.
REQ-031 Sub-module edge_rise (Clk, nReset, D_In, Pulse_Out) shall be instantiated once per button.
REQ-032 The turbo counter width shall be 8 bits.

Verification
REQ-033 Reset, then 4 Up pulses: Thermo_Out steps 0001, 0010, 0100, 1000; a 5th Up holds 1000 and gives a 1-cycle Err_Out.
REQ-034 In LOW_COOL, Turbo pulse with TURBO_CYCLES=16: Turbo_Out high for exactly 16 cycles, then 0 with mode unchanged.
REQ-035 In HIGH_FAN, Turbo pulse: Turbo_Out stays 0 and Err_Out pulses once; then Up+Turbo in the same cycle gives 0100 with Turbo_Out=1.
REQ-036 In HIGH_COOL with turbo on, Up+Down+Off in the same cycle: 0000, Turbo_Out=0, Err_Out=0.
REQ-037 Up held high for 10 cycles: exactly one step; Up+Down together: no change, one Err_Out pulse.
REQ-038 nReset pulsed low mid-turbo with Up held through release: outputs 0000/0/0, and no step after release until Up is re-pressed.
